// File: rtl/mips_cpu_mem_unit_pkg.sv
// Shared types for the MIPS memory unit: access sizes, FSM states, and byte-lane masks.
package mips_cpu_mem_unit_pkg;

  typedef enum logic [2:0] {
    SZ_BYTE  = 3'd0,
    SZ_HALF  = 3'd1,
    SZ_WORD  = 3'd2,
    SZ_DWORD = 3'd3,
    SZ_LEFT  = 3'd4,
    SZ_RIGHT = 3'd5
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mem_state_t;

  localparam logic [7:0] MASK_BYTE  = 8'h01;
  localparam logic [7:0] MASK_HALF  = 8'h03;
  localparam logic [7:0] MASK_WORD  = 8'h0F;
  localparam logic [7:0] MASK_DWORD = 8'hFF;

  function automatic logic [7:0] size_mask(input logic [2:0] size);
    case (size)
      SZ_BYTE:  return MASK_BYTE;
      SZ_HALF:  return MASK_HALF;
      SZ_WORD:  return MASK_WORD;
      SZ_DWORD: return MASK_DWORD;
      default:  return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_mem_unit_if.sv
// Avalon-MM bus between the memory unit (master) and the memory fabric (slave).
interface mips_cpu_mem_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              waitrequest;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic [BE_W-1:0]   byteenable;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/mips_cpu_mem_unit_lane_steer.sv
// Combinational byte-lane steering: store byteenable/writedata, load extract/extend.
// MEM_UNALIGNED_EN enables big-endian SZ_LEFT/SZ_RIGHT (LWL/LWR/SWL/SWR) for DATA_W=32.
module mips_cpu_mem_unit_lane_steer
  import mips_cpu_mem_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int LANE_W = $clog2(BE_W)
) (
  input  logic [2:0]        st_size,
  input  logic [LANE_W-1:0] st_lane,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_legal,
  output logic [BE_W-1:0]   st_be,
  output logic [DATA_W-1:0] st_data,
  input  logic [2:0]        ld_size,
  input  logic [LANE_W-1:0] ld_lane,
  input  logic              ld_signed,
  input  logic [DATA_W-1:0] ld_rt,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_result
);

  logic [LANE_W+2:0] st_sh;
  logic [LANE_W+2:0] ld_sh;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] low_mask;

  assign st_sh   = {st_lane, 3'b000};
  assign ld_sh   = {ld_lane, 3'b000};
  assign shifted = ld_rdata >> ld_sh;

`ifdef MEM_UNALIGNED_EN
  logic [1:0] st_rs;
  logic [1:0] ld_rs;
  assign st_rs = 2'd3 - st_lane[1:0];
  assign ld_rs = 2'd3 - ld_lane[1:0];
`else
  logic unused_rt;
  assign unused_rt = ^ld_rt;
`endif

  always_comb begin
    st_be   = BE_W'(size_mask(st_size)) << st_lane;
    st_data = st_wdata << st_sh;
    case (st_size)
      SZ_BYTE:  st_legal = 1'b1;
      SZ_HALF:  st_legal = ~st_lane[0];
      SZ_WORD:  st_legal = (st_lane[1:0] == 2'b00);
      SZ_DWORD: st_legal = (DATA_W == 64) && (st_lane == '0);
`ifdef MEM_UNALIGNED_EN
      // big-endian: lower address offsets live in the upper lanes
      SZ_LEFT: begin
        st_legal = (DATA_W == 32);
        st_be    = BE_W'(4'hF >> st_lane[1:0]);
        st_data  = st_wdata >> {st_lane[1:0], 3'b000};
      end
      SZ_RIGHT: begin
        st_legal = (DATA_W == 32);
        st_be    = BE_W'(4'hF << st_rs);
        st_data  = st_wdata << {st_rs, 3'b000};
      end
`endif
      default:  st_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (ld_size)
      SZ_BYTE: low_mask = DATA_W'(8'hFF);
      SZ_HALF: low_mask = DATA_W'(16'hFFFF);
      SZ_WORD: low_mask = DATA_W'(32'hFFFF_FFFF);
      default: low_mask = '1;
    endcase
    ld_result = shifted & low_mask;
    // low_mask ^ (low_mask >> 1) isolates the sign bit of the selected width
    if (ld_signed && (|(shifted & (low_mask ^ (low_mask >> 1)))))
      ld_result = ld_result | ~low_mask;
`ifdef MEM_UNALIGNED_EN
    if (ld_size == SZ_LEFT)
      ld_result = (ld_rdata << {ld_lane[1:0], 3'b000}) |
                  (ld_rt & ~({DATA_W{1'b1}} << {ld_lane[1:0], 3'b000}));
    else if (ld_size == SZ_RIGHT)
      ld_result = (ld_rdata >> {ld_rs, 3'b000}) |
                  (ld_rt & ~({DATA_W{1'b1}} >> {ld_rs, 3'b000}));
`endif
  end

endmodule

// File: rtl/mips_cpu_mem_unit.sv
// Avalon-MM load/store master for the multicycle MIPS core, one transaction at a time.
// Optional MEM_UNALIGNED_EN (in the lane steer) adds LWL/LWR/SWL/SWR.
//
// state | meaning
// IDLE  | req_ready high, waiting for a core request
// BUS   | read/write strobe held until waitrequest drops
// DONE  | resp_valid pulse carrying the extended load data
// ERR   | resp_valid + resp_err pulse, no bus cycle issued
module mips_cpu_mem_unit
  import mips_cpu_mem_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_write,
  input  logic [2:0]          req_size,
  input  logic                req_signed,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  mips_cpu_mem_unit_if.master bus
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BE_W - 1);

  mem_state_t        state;
  logic              st_legal;
  logic [BE_W-1:0]   st_be;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] ld_result;

  logic [2:0]        sv_size;
  logic [LANE_W-1:0] sv_lane;
  logic              sv_signed;
  logic              sv_write;
  logic [DATA_W-1:0] sv_rt;

  mips_cpu_mem_unit_lane_steer #(.DATA_W(DATA_W)) u_lane_steer (
    .st_size   (req_size),
    .st_lane   (req_addr[LANE_W-1:0]),
    .st_wdata  (req_wdata),
    .st_legal  (st_legal),
    .st_be     (st_be),
    .st_data   (st_data),
    .ld_size   (sv_size),
    .ld_lane   (sv_lane),
    .ld_signed (sv_signed),
    .ld_rt     (sv_rt),
    .ld_rdata  (bus.readdata),
    .ld_result (ld_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.address    <= '0;
      bus.byteenable <= '0;
      bus.writedata  <= '0;
      sv_size        <= '0;
      sv_lane        <= '0;
      sv_signed      <= 1'b0;
      sv_write       <= 1'b0;
      sv_rt          <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            if (st_legal) begin
              state          <= BUS;
              bus.read       <= ~req_write;
              bus.write      <= req_write;
              bus.address    <= req_addr & ALIGN_MASK;
              bus.byteenable <= st_be;
              bus.writedata  <= st_data;
              sv_size        <= req_size;
              sv_lane        <= req_addr[LANE_W-1:0];
              sv_signed      <= req_signed;
              sv_write       <= req_write;
              sv_rt          <= req_wdata;
            end else begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end
          end
        end
        BUS: begin
          if (!bus.waitrequest) begin
            state      <= DONE;
            bus.read   <= 1'b0;
            bus.write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= sv_write ? '0 : ld_result;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_unit.sv
// Self-checking bench for mips_cpu_mem_unit: byte-level reference model plus directed pins.
module tb_mips_cpu_mem_unit;
  import mips_cpu_mem_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [2:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  mips_cpu_mem_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mips_cpu_mem_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit          chk_en = 1'b0;
  bit          exp_ready, exp_read, exp_write, exp_rvalid, exp_rerr;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;

  logic [31:0] seen_wd, last_rdata;
  logic [3:0]  seen_be;
  bit          last_err;
  int          strobe_cycles, resp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte-granular view of the access; lanes outside byteenable are don't-care.
  function automatic void model(input logic [31:0] addr, input bit wr, input logic [2:0] sz,
                                input bit sgn, input logic [31:0] wd, input logic [31:0] rd,
                                output bit err, output logic [31:0] ab, output logic [3:0] be,
                                output logic [31:0] wdo, output logic [31:0] res);
    int o, n, j;
    bit lr;
    logic [7:0] b;
    o = int'(addr[1:0]);
    n = 0;
    lr = 1'b0;
    err = 1'b0;
    ab = addr & 32'hFFFF_FFFC;
    be = '0;
    wdo = '0;
    res = '0;
    case (sz)
      SZ_BYTE: n = 1;
      SZ_HALF: n = 2;
      SZ_WORD: n = 4;
`ifdef MEM_UNALIGNED_EN
      SZ_LEFT, SZ_RIGHT: lr = 1'b1;
`endif
      default: n = 0;
    endcase
    if (lr) begin
      // big-endian: memory offset k sits in lane 3-k
      res = wd;
      for (int k = 0; k < 4; k++) begin
        if (sz == SZ_LEFT && k < o) continue;
        if (sz == SZ_RIGHT && k > o) continue;
        j = (sz == SZ_LEFT) ? 3 - (k - o) : o - k;
        if (wr) begin
          be = be | 4'(1 << (3 - k));
          b = 8'(wd >> (8 * j));
          wdo = wdo | (32'(b) << (8 * (3 - k)));
        end else begin
          be = be | 4'(1 << (3 - k));
          b = 8'(rd >> (8 * (3 - k)));
          res = (res & ~(32'hFF << (8 * j))) | (32'(b) << (8 * j));
        end
      end
      if (wr) res = '0;
      return;
    end
    if (n == 0 || (o % n) != 0) begin
      err = 1'b1;
      ab = '0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      be = be | 4'(1 << (o + i));
      b = 8'(wd >> (8 * i));
      wdo = wdo | (32'(b) << (8 * (o + i)));
      b = 8'(rd >> (8 * (o + i)));
      res = res | (32'(b) << (8 * i));
    end
    if (sgn && res[8*n-1])
      for (int i = n; i < 4; i++) res = res | (32'hFF << (8 * i));
    if (wr) res = '0;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("read", 32'(bus_if.read), 32'(exp_read));
      check("write", 32'(bus_if.write), 32'(exp_write));
      if (exp_read || exp_write) begin
        check("address", bus_if.address, exp_addr);
        check("byteenable", 32'(bus_if.byteenable), 32'(exp_be));
        if (exp_write)
          check("writedata", bus_if.writedata & lane_mask(exp_be), exp_wdata & lane_mask(exp_be));
      end
      check("resp_valid", 32'(resp_valid), 32'(exp_rvalid));
      if (exp_rvalid) begin
        check("resp_err", 32'(resp_err), 32'(exp_rerr));
        check("resp_rdata", resp_rdata, exp_rdata);
      end
      if (bus_if.read || bus_if.write) begin
        strobe_cycles++;
        seen_be = bus_if.byteenable;
        seen_wd = bus_if.writedata;
      end
      if (resp_valid) begin
        resp_count++;
        last_rdata = resp_rdata;
        last_err = resp_err;
      end
    end
  end

  task automatic scramble_req();
    req_valid  = 1'($urandom_range(0, 1));
    req_addr   = $urandom;
    req_write  = 1'($urandom_range(0, 1));
    req_size   = 3'($urandom_range(0, 7));
    req_signed = 1'($urandom_range(0, 1));
    req_wdata  = $urandom;
  endtask

  task automatic run_txn(input logic [31:0] addr, input bit wr, input logic [2:0] sz, input bit sgn,
                         input logic [31:0] wd, input logic [31:0] rd, input int nwait);
    bit err;
    logic [31:0] ab, wdo, res;
    logic [3:0] be;
    model(addr, wr, sz, sgn, wd, rd, err, ab, be, wdo, res);
    strobe_cycles = 0;
    resp_count = 0;
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_size = sz;
    req_signed = sgn; req_wdata = wd;
    exp_ready = 1'b1; exp_read = 1'b0; exp_write = 1'b0; exp_rvalid = 1'b0; exp_rerr = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #2;
    scramble_req();
    exp_ready = 1'b0;
    if (err) begin
      exp_rvalid = 1'b1; exp_rerr = 1'b1; exp_rdata = '0;
      @(posedge clk); #2;
    end else begin
      exp_read = !wr; exp_write = wr; exp_addr = ab; exp_be = be; exp_wdata = wdo;
      for (int i = 0; i <= nwait; i++) begin
        bus_if.waitrequest = (i < nwait);
        bus_if.readdata = (i < nwait) ? $urandom : rd;
        @(posedge clk); #2;
        scramble_req();
      end
      bus_if.waitrequest = 1'($urandom_range(0, 1));
      bus_if.readdata = $urandom;
      exp_read = 1'b0; exp_write = 1'b0;
      exp_rvalid = 1'b1; exp_rerr = 1'b0; exp_rdata = res;
      @(posedge clk); #2;
    end
    req_valid = 1'b0;
    exp_ready = 1'b1; exp_read = 1'b0; exp_write = 1'b0; exp_rvalid = 1'b0; exp_rerr = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bus_if.waitrequest = 1'b0;
    bus_if.readdata = '0;
    #1;
    check("rst_read", 32'(bus_if.read), 32'd0);
    check("rst_write", 32'(bus_if.write), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_address", bus_if.address, 32'd0);
    check("rst_byteenable", 32'(bus_if.byteenable), 32'd0);
    check("rst_writedata", bus_if.writedata, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    check("rst_req_ready", 32'(req_ready), 32'd1);

    run_txn(32'hBFC0_0000, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h3C02_1234, 0);
    check("lw_rdata", last_rdata, 32'h3C02_1234);
    check("lw_be", 32'(seen_be), 32'h0000_000F);
    check("lw_strobes", 32'(strobe_cycles), 32'd1);

    run_txn(32'h0000_1003, 1'b0, SZ_BYTE, 1'b1, 32'h0, 32'hF000_0000, 1);
    check("lb_rdata", last_rdata, 32'hFFFF_FFF0);
    check("lb_be", 32'(seen_be), 32'h0000_0008);
    run_txn(32'h0000_1003, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'hF000_0000, 0);
    check("lbu_rdata", last_rdata, 32'h0000_00F0);

    run_txn(32'h0000_2002, 1'b1, SZ_HALF, 1'b0, 32'h0000_ABCD, 32'h0, 3);
    check("sh_strobes", 32'(strobe_cycles), 32'd4);
    check("sh_be", 32'(seen_be), 32'h0000_000C);
    check("sh_wdata", seen_wd, 32'hABCD_0000);
    check("sh_resp_count", 32'(resp_count), 32'd1);

    run_txn(32'h0000_2001, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 0);
    check("lw_misaligned_err", 32'(last_err), 32'd1);
    check("lw_misaligned_strobes", 32'(strobe_cycles), 32'd0);

    run_txn(32'h0000_1001, 1'b0, SZ_LEFT, 1'b0, 32'hAABB_CCDD, 32'h1122_3344, 0);
`ifdef MEM_UNALIGNED_EN
    check("lwl_rdata", last_rdata, 32'h2233_44DD);
    check("lwl_err", 32'(last_err), 32'd0);
`else
    check("lwl_err", 32'(last_err), 32'd1);
    check("lwl_strobes", 32'(strobe_cycles), 32'd0);
`endif

    run_txn(32'h0000_4000, 1'b0, SZ_DWORD, 1'b0, 32'h0, 32'h0, 0);
    check("dword_err", 32'(last_err), 32'd1);

    for (int t = 0; t < 400; t++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #2;
      end
    end

    // reset while a read is stalled on the bus
    chk_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0000_3000; req_write = 1'b0;
    req_size = SZ_WORD; req_signed = 1'b0;
    bus_if.waitrequest = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_read", 32'(bus_if.read), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst_read", 32'(bus_if.read), 32'd0);
    check("midrst_write", 32'(bus_if.write), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    bus_if.waitrequest = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("midrst_ready", 32'(req_ready), 32'd1);
      check("midrst_no_resp", 32'(resp_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
